// File: rtl/viola_pkg.sv
// Shared definitions for the ALU reservation station: opcodes, tag width and entry layout.
package viola_pkg;

  localparam int TAG_W = 3;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SUB  = 5'b00001;
  localparam logic [4:0] SLL  = 5'b00010;
  localparam logic [4:0] SLT  = 5'b00011;
  localparam logic [4:0] SLTU = 5'b00100;
  localparam logic [4:0] XOR  = 5'b00101;
  localparam logic [4:0] SRL  = 5'b00110;
  localparam logic [4:0] SRA  = 5'b00111;
  localparam logic [4:0] OR   = 5'b01000;
  localparam logic [4:0] AND  = 5'b01001;
  localparam logic [4:0] EQ   = 5'b10110;
  localparam logic [4:0] NE   = 5'b10111;
  localparam logic [4:0] LT   = 5'b11000;
  localparam logic [4:0] GE   = 5'b11001;
  localparam logic [4:0] GEU  = 5'b11010;
  localparam logic [4:0] LTU  = 5'b11011;

  typedef struct packed {
    logic             busy;
    logic [4:0]       op;
    logic [TAG_W-1:0] des;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             is_branch;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index picker: one-hot grant, binary index and any-request flag.
module rs_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = IW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: DEPTH entries with tag wakeup from the ALU and load-store broadcasts.
// Optional macro ALU_RS_BYPASS_EN issues a ready dispatch straight through when nothing stored is ready.
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pause,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [4:0]             in_op,
  input  logic [TAG_W-1:0]       in_des,
  input  logic [31:0]            in_vj,
  input  logic [31:0]            in_vk,
  input  logic [TAG_W-1:0]       in_qj,
  input  logic [TAG_W-1:0]       in_qk,
  input  logic                   in_is_branch,
  input  logic [TAG_W-1:0]       alu_des,
  input  logic [31:0]            alu_result,
  input  logic [TAG_W-1:0]       lsb_des,
  input  logic [31:0]            lsb_result,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            value_1,
  output logic [31:0]            value_2,
  output logic [4:0]             op,
  output logic [TAG_W-1:0]       des,
  output logic                   is_branch
);
  import viola_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int SW = TAG_W + 32;

  // Returns {tag, value}; the ALU broadcast wins when both buses carry the same tag.
  function automatic logic [SW-1:0] snoop(
    input logic [TAG_W-1:0] q,     input logic [31:0] v,
    input logic [TAG_W-1:0] a_tag, input logic [31:0] a_val,
    input logic [TAG_W-1:0] l_tag, input logic [31:0] l_val
  );
    if (q != '0 && q == a_tag) return {{TAG_W{1'b0}}, a_val};
    if (q != '0 && q == l_tag) return {{TAG_W{1'b0}}, l_val};
    return {q, v};
  endfunction

  logic [DEPTH-1:0] busy_reg, busy_next, ready, issue_oh, alloc_oh;
  logic [IW-1:0]    alloc_idx, issue_idx;
  logic             alloc_found, issue_found;
  logic [SW-1:0]    in_j, in_k;
  logic             dispatch_ok, bypass, store, issue_fire;
  logic [CW-1:0]    count_reg, count_next;
  logic [31:0]      value_1_reg, value_1_next, value_2_reg, value_2_next;
  logic [4:0]       op_reg, op_next;
  logic [TAG_W-1:0] des_reg, des_next;
  logic             is_branch_reg, is_branch_next;

  logic [4:0]       e_op  [DEPTH];
  logic [TAG_W-1:0] e_des [DEPTH];
  logic [31:0]      e_vj  [DEPTH];
  logic [31:0]      e_vk  [DEPTH];
  logic             e_br  [DEPTH];

  rs_prio_enc #(.N(DEPTH), .IW(IW)) u_alloc (
    .req(~busy_reg), .onehot(alloc_oh), .idx(alloc_idx), .found(alloc_found)
  );
  rs_prio_enc #(.N(DEPTH), .IW(IW)) u_issue (
    .req(ready), .onehot(issue_oh), .idx(issue_idx), .found(issue_found)
  );

  assign full        = !alloc_found;
  assign in_j        = snoop(in_qj, in_vj, alu_des, alu_result, lsb_des, lsb_result);
  assign in_k        = snoop(in_qk, in_vk, alu_des, alu_result, lsb_des, lsb_result);
  assign dispatch_ok = in_valid && alloc_found && !flush;
  assign issue_fire  = issue_found && !pause && !flush;

`ifdef ALU_RS_BYPASS_EN
  assign bypass = dispatch_ok && !pause && !issue_found &&
                  in_j[SW-1:32] == '0 && in_k[SW-1:32] == '0;
`else
  assign bypass = 1'b0;
`endif

  assign store = dispatch_ok && !bypass;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [4:0]       op_q;
    logic [TAG_W-1:0] des_q, qj_q, qk_q;
    logic [31:0]      vj_q, vk_q;
    logic             br_q;
    logic [SW-1:0]    j_next, k_next;
    logic             we;

    assign we = store && alloc_idx == IW'(gi);

    always_comb begin
      j_next = snoop(qj_q, vj_q, alu_des, alu_result, lsb_des, lsb_result);
      k_next = snoop(qk_q, vk_q, alu_des, alu_result, lsb_des, lsb_result);
      if (we) begin
        j_next = in_j;
        k_next = in_k;
      end
    end

    always_ff @(posedge clk) begin
      {qj_q, vj_q} <= j_next;
      {qk_q, vk_q} <= k_next;
      if (we) begin
        op_q  <= in_op;
        des_q <= in_des;
        br_q  <= in_is_branch;
      end
    end

    assign ready[gi] = busy_reg[gi] && qj_q == '0 && qk_q == '0;
    assign e_op[gi]  = op_q;
    assign e_des[gi] = des_q;
    assign e_vj[gi]  = vj_q;
    assign e_vk[gi]  = vk_q;
    assign e_br[gi]  = br_q;
  end

  always_comb begin
    busy_next = busy_reg;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (issue_fire) busy_next = busy_next & ~issue_oh;
      if (store)      busy_next = busy_next | alloc_oh;
    end
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) count_next = count_next + CW'(busy_next[i]);
  end

  always_comb begin
    value_1_next   = value_1_reg;
    value_2_next   = value_2_reg;
    op_next        = op_reg;
    des_next       = des_reg;
    is_branch_next = is_branch_reg;
    if (flush || (!pause && !issue_found && !bypass)) begin
      value_1_next   = '0;
      value_2_next   = '0;
      op_next        = '0;
      des_next       = '0;
      is_branch_next = 1'b0;
    end else if (!pause && issue_found) begin
      value_1_next   = e_vj[issue_idx];
      value_2_next   = e_vk[issue_idx];
      op_next        = e_op[issue_idx];
      des_next       = e_des[issue_idx];
      is_branch_next = e_br[issue_idx];
    end else if (!pause && bypass) begin
      value_1_next   = in_j[31:0];
      value_2_next   = in_k[31:0];
      op_next        = in_op;
      des_next       = in_des;
      is_branch_next = in_is_branch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg      <= '0;
      count_reg     <= '0;
      value_1_reg   <= '0;
      value_2_reg   <= '0;
      op_reg        <= '0;
      des_reg       <= '0;
      is_branch_reg <= 1'b0;
    end else begin
      busy_reg      <= busy_next;
      count_reg     <= count_next;
      value_1_reg   <= value_1_next;
      value_2_reg   <= value_2_next;
      op_reg        <= op_next;
      des_reg       <= des_next;
      is_branch_reg <= is_branch_next;
    end
  end

  assign count     = count_reg;
  assign value_1   = value_1_reg;
  assign value_2   = value_2_reg;
  assign op        = op_reg;
  assign des       = des_reg;
  assign is_branch = is_branch_reg;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic against a cycle-level model.
module tb_alu_rs;
  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
  localparam int TMAX  = (1 << TAG_W) - 1;

  logic             clk = 1'b0;
  logic             rst, pause, flush, in_valid, in_is_branch;
  logic [4:0]       in_op;
  logic [TAG_W-1:0] in_des, in_qj, in_qk, alu_des, lsb_des;
  logic [31:0]      in_vj, in_vk, alu_result, lsb_result;
  logic             full, is_branch;
  logic [$clog2(DEPTH):0] count;
  logic [31:0]      value_1, value_2;
  logic [4:0]       op;
  logic [TAG_W-1:0] des;

  always #5 clk = ~clk;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_des(in_des),
    .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .in_is_branch(in_is_branch),
    .alu_des(alu_des), .alu_result(alu_result),
    .lsb_des(lsb_des), .lsb_result(lsb_result),
    .full(full), .count(count), .value_1(value_1), .value_2(value_2),
    .op(op), .des(des), .is_branch(is_branch)
  );

  // Reference state: a plain table of waiting instructions plus the expected output bundle.
  bit               m_busy [DEPTH];
  logic [4:0]       m_op   [DEPTH];
  logic [TAG_W-1:0] m_des  [DEPTH];
  logic [TAG_W-1:0] m_qj   [DEPTH];
  logic [TAG_W-1:0] m_qk   [DEPTH];
  logic [31:0]      m_vj   [DEPTH];
  logic [31:0]      m_vk   [DEPTH];
  logic             m_br   [DEPTH];
  logic [31:0]      x_v1, x_v2;
  logic [4:0]       x_op;
  logic [TAG_W-1:0] x_des;
  logic             x_br;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic bit m_full();
    return m_count() == DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    x_v1 = '0; x_v2 = '0; x_op = '0; x_des = '0; x_br = 1'b0;
  endtask

  task automatic resolve(inout logic [TAG_W-1:0] q, inout logic [31:0] v);
    if (q != 0 && q == alu_des) begin
      v = alu_result; q = '0;
    end else if (q != 0 && q == lsb_des) begin
      v = lsb_result; q = '0;
    end
  endtask

  task automatic model_step();
    int iss = -1;
    int slot = -1;
    bit was_full, byp;
    logic [TAG_W-1:0] jq, kq;
    logic [31:0] jv, kv;
    if (flush) begin
      model_reset();
      return;
    end
    was_full = m_full();
    for (int i = 0; i < DEPTH; i++)
      if (iss < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) iss = i;
    for (int i = 0; i < DEPTH; i++)
      if (slot < 0 && !m_busy[i]) slot = i;
    jq = in_qj; jv = in_vj; resolve(jq, jv);
    kq = in_qk; kv = in_vk; resolve(kq, kv);
    byp = 1'b0;
`ifdef ALU_RS_BYPASS_EN
    byp = in_valid && !was_full && !pause && iss < 0 && jq == 0 && kq == 0;
`endif
    if (!pause) begin
      if (iss >= 0) begin
        x_v1 = m_vj[iss]; x_v2 = m_vk[iss]; x_op = m_op[iss]; x_des = m_des[iss]; x_br = m_br[iss];
        m_busy[iss] = 1'b0;
      end else if (byp) begin
        x_v1 = jv; x_v2 = kv; x_op = in_op; x_des = in_des; x_br = in_is_branch;
      end else begin
        x_v1 = '0; x_v2 = '0; x_op = '0; x_des = '0; x_br = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i]) begin
        resolve(m_qj[i], m_vj[i]);
        resolve(m_qk[i], m_vk[i]);
      end
    end
    if (in_valid && !was_full && !byp) begin
      m_busy[slot] = 1'b1;
      m_op[slot] = in_op; m_des[slot] = in_des; m_br[slot] = in_is_branch;
      m_qj[slot] = jq; m_vj[slot] = jv; m_qk[slot] = kq; m_vk[slot] = kv;
    end
  endtask

  task automatic check_all();
    chk("des", 32'(des), 32'(x_des));
    chk("op", 32'(op), 32'(x_op));
    chk("value_1", value_1, x_v1);
    chk("value_2", value_2, x_v2);
    chk("is_branch", 32'(is_branch), 32'(x_br));
    chk("count", 32'(count), 32'(m_count()));
  endtask

  // One clock: check full, advance the model, compare after the edge, return to the falling edge.
  task automatic step();
    chk("full", 32'(full), 32'(m_full()));
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; pause = 1'b0; flush = 1'b0;
    alu_des = '0; lsb_des = '0; alu_result = '0; lsb_result = '0;
  endtask

  task automatic set_disp(input logic [4:0] o, input logic [TAG_W-1:0] d, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [TAG_W-1:0] qj,
                          input logic [TAG_W-1:0] qk, input logic br);
    in_valid = 1'b1; in_op = o; in_des = d; in_vj = vj; in_vk = vk;
    in_qj = qj; in_qk = qk; in_is_branch = br;
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    chk("rst_des", 32'(des), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_value_1", value_1, 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    set_disp(5'd0, '0, '0, '0, '0, '0, 1'b0);
    in_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("full_rst", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Ready ADD 5+7
    set_disp(viola_pkg::ADD, 3'd1, 32'd5, 32'd7, 3'd0, 3'd0, 1'b0);
    step();
`ifdef ALU_RS_BYPASS_EN
    chk("byp_des", 32'(des), 32'd1);
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("add_count1", 32'(count), 32'd1);
    chk("add_des1", 32'(des), 32'd0);
`endif
    idle();
    step();
`ifndef ALU_RS_BYPASS_EN
    chk("add_v1", value_1, 32'd5);
    chk("add_v2", value_2, 32'd7);
    chk("add_des2", 32'(des), 32'd1);
    chk("add_count2", 32'(count), 32'd0);
`endif

    // SUB waiting on tag 3, woken by the ALU with 100
    set_disp(viola_pkg::SUB, 3'd2, 32'd0, 32'd9, 3'd3, 3'd0, 1'b0);
    step();
    idle();
    alu_des = 3'd3; alu_result = 32'd100;
    step();
    chk("sub_wait_des", 32'(des), 32'd0);
    idle();
    step();
    chk("sub_v1", value_1, 32'd100);
    chk("sub_op", 32'(op), 32'(viola_pkg::SUB));
    chk("sub_des", 32'(des), 32'd2);

    // Fill all entries on tag 5, drop a fifth, then wake them with the LSB bus
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(viola_pkg::ADD, 3'(i + 1), 32'd0, 32'(i), 3'd5, 3'd0, 1'b0);
      step();
    end
    chk("fill_full", 32'(full), 32'd1);
    set_disp(viola_pkg::ADD, 3'd6, 32'd1, 32'd1, 3'd0, 3'd0, 1'b0);
    step();
    chk("drop_count", 32'(count), 32'd4);
    idle();
    lsb_des = 3'd5; lsb_result = 32'd55;
    step();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("order_des", 32'(des), 32'(i + 1));
      chk("order_v1", value_1, 32'd55);
    end

    // Pause holds outputs while a ready entry waits
    set_disp(viola_pkg::XOR, 3'd7, 32'd11, 32'd22, 3'd0, 3'd0, 1'b1);
    pause = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) step();
    chk("pause_des", 32'(des), 32'd4);
    chk("pause_count", 32'(count), 32'd1);
    pause = 1'b0;
    step();
    chk("unpause_des", 32'(des), 32'd7);
    chk("unpause_br", 32'(is_branch), 32'd1);

    // Flush beats a concurrent dispatch
    for (int i = 0; i < 3; i++) begin
      set_disp(viola_pkg::OR, 3'(i + 1), 32'd3, 32'd4, 3'd6, 3'd0, 1'b0);
      step();
    end
    set_disp(viola_pkg::AND, 3'd4, 32'd1, 32'd2, 3'd0, 3'd0, 1'b0);
    flush = 1'b1;
    step();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_des", 32'(des), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    idle();

    // Asynchronous reset with work pending
    set_disp(viola_pkg::ADD, 3'd5, 32'd1, 32'd2, 3'd0, 3'd0, 1'b0);
    step();
    set_disp(viola_pkg::ADD, 3'd6, 32'd3, 32'd4, 3'd0, 3'd0, 1'b0);
    step();
    async_reset();
    step();
    chk("post_rst_des", 32'(des), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      in_valid     = ($urandom_range(0, 9) < 6);
      in_op        = 5'($urandom_range(0, 31));
      in_des       = TAG_W'($urandom_range(1, TMAX));
      in_vj        = $urandom;
      in_vk        = $urandom;
      in_qj        = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, TMAX));
      in_qk        = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, TMAX));
      in_is_branch = 1'($urandom_range(0, 1));
      alu_des      = ($urandom_range(0, 1) == 0) ? '0 : TAG_W'($urandom_range(1, TMAX));
      alu_result   = $urandom;
      lsb_des      = ($urandom_range(0, 2) == 0) ? alu_des : TAG_W'($urandom_range(0, TMAX));
      lsb_result   = $urandom;
      pause        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      if (n == 300) async_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
